// File: rtl/struct_pair_packer.sv
// Packs consecutive int words of a valid/ready stream into {a,b} structs.
// Odd bursts closed by in_last flush a partial struct with b zeroed.
module struct_pair_packer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_struct,
  output logic                out_partial,
  output logic                out_last,
  output logic [CNT_W-1:0]    pair_count
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_a_q, hold_a_d;
  pair_t             out_q, out_d;
  logic              valid_q, valid_d;
  logic              part_q, part_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic out_space;
  logic accept;
  logic out_hs;
  logic rdy;

  assign out_space = !valid_q || out_ready;
  assign out_hs    = valid_q && out_ready;
  assign accept    = in_valid && rdy;

  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      IDLE:    rdy = 1'b1;
      HAVE_A:  rdy = out_space;
      FLUSH:   rdy = 1'b0;
      default: rdy = 1'b0;
    endcase
  end

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign in_ready = rdy && !rst;

  always_comb begin
    state_d  = state_q;
    hold_a_d = hold_a_q;
    out_d    = out_q;
    part_d   = part_q;
    last_d   = last_q;
    valid_d  = out_hs ? 1'b0 : valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_a_d = in_data;
          state_d  = in_last ? FLUSH : HAVE_A;
        end
      end
      HAVE_A: begin
        if (accept) begin
          out_d.a = hold_a_q;
          out_d.b = in_data;
          valid_d = 1'b1;
          part_d  = 1'b0;
          last_d  = in_last;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (out_space) begin
          out_d.a = hold_a_q;
          out_d.b = '0;
          valid_d = 1'b1;
          part_d  = 1'b1;
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && !part_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_a_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      part_q   <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      part_q   <= part_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_struct  = out_q;
  assign out_partial = part_q;
  assign out_last    = last_q;
  assign pair_count  = cnt_q;

endmodule

// File: doc/struct_pair_packer.md
Name: struct_pair_packer

Overview:
- Upstream feeder for the struct-consuming stage that takes a packed StructType {int a; int b;}.
- Accepts a valid/ready stream of 32-bit int words and packs each consecutive pair into one 64-bit packed struct: first word -> field a, second word -> field b.
- Drives the struct on a registered valid/ready output.
- Handles odd-length bursts terminated by in_last by emitting a partial struct with b zeroed.

Parameters:
- DATA_W, 32, width of one int field; struct width is 2*DATA_W.
- CNT_W, 16, width of the saturating completed-pair counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid && in_ready.
- in_data  input  DATA_W  input int word.
- in_last  input  1  marks final word of a burst; sampled only on accept.
- out_valid  output  1  out_struct valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_struct  output  2*DATA_W  packed struct; a = [2*DATA_W-1:DATA_W], b = [DATA_W-1:0].
- out_partial  output  1  struct carries only field a; b forced to 0.
- out_last  output  1  struct closes a burst.
- pair_count  output  CNT_W  number of full (non-partial) structs delivered.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the environment):
  - state=IDLE; hold_a=0.
  - out_valid=0, out_struct=0, out_partial=0, out_last=0, pair_count=0.
  - in_ready=0 while rst is high.
- Output register is single-entry. out_space = !out_valid || out_ready.
- in_ready is a function of state and out_space only, never of in_valid, in_data or in_last:
  - IDLE: in_ready=1.
  - HAVE_A: in_ready=out_space.
  - FLUSH: in_ready=0.
- FSM transitions:
  - IDLE, accept with in_last=0: hold_a<=in_data; go to HAVE_A.
  - IDLE, accept with in_last=1: hold_a<=in_data; go to FLUSH.
  - HAVE_A, accept: load out_struct={hold_a,in_data}, out_valid<=1, out_partial<=0, out_last<=in_last; go to IDLE.
  - FLUSH, out_space=1: load out_struct={hold_a,0}, out_valid<=1, out_partial<=1, out_last<=1; go to IDLE.
  - FLUSH, out_space=0: stay in FLUSH.
  - No input accept: state holds.
- Output register:
  - Holds value and flags stable while out_valid && !out_ready.
  - Clears out_valid on a handshake with no same-cycle reload.
  - Handshake plus same-cycle reload from HAVE_A or FLUSH: new value loaded, out_valid stays 1 (back-to-back, no bubble).
- Latency: struct is visible the cycle after the b word (or flush) is accepted. Sustained throughput is one struct per two input cycles with out_ready held high.
- IDLE accept does not require output space; word a may be captured while a previous struct is stalled.
- pair_count:
  - Increments by 1 on each output handshake with out_partial=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Partial structs do not count.
- in_last on the a word of an odd burst always yields exactly one partial struct, never merged with the next burst.
- in_data and in_last are don't-care when not accepted. out_struct is don't-care-free: it holds its last loaded value after out_valid drops.
- Reset mid-operation: a held a word or a pending struct is discarded, nothing is emitted, and all outputs return to reset values immediately (async).

Test Plan:
- Pair pack: words 0x0000_0000, 0x0000_0001 with out_ready=1 -> one struct 0x00000000_00000001, partial=0, last=0; pair_count=1.
- Odd burst: single word 0xDEAD_BEEF with in_last=1 -> struct 0xDEADBEEF_00000000 with partial=1, last=1, emitted from FLUSH one cycle after accept; pair_count unchanged.
- Backpressure: hold out_ready=0 after first struct, send words 5,6,7 ->
  - word 5 is accepted into hold_a;
  - in_ready=0 in HAVE_A until out_ready rises;
  - first struct is stable throughout;
  - then {5,6} follows with no bubble;
  - 7 is held until the next word.
- Streaming: 8 words 1..8, in_valid and out_ready always 1, in_last on word 8 -> structs {1,2},{3,4},{5,6},{7,8} on alternate cycles; last=1 only on {7,8}; pair_count=4.
- Saturation: CNT_W=2, deliver 5 full pairs -> pair_count reads 1,2,3,3,3.
- Async reset: assert rst while in HAVE_A holding 0x1234 with out_valid=1 -> all outputs clear without a clock edge. After release, words 9,10 produce {9,10}; no stale 0x1234 appears.
